// File: rtl/store_pack_buffer.sv
// Store packer: narrows a right-aligned store operand onto byte lanes and queues it toward memory.
// Latency 1 cycle accept-to-output; in_ready drops when full, illegal stores are reported and dropped.
module store_pack_buffer #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AW-1:0]          in_addr,
   input  logic [31:0]            in_wdata,
   input  logic [1:0]             in_type,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AW-1:0]          out_addr,
   output logic [3:0]             out_byteen,
   output logic [31:0]            out_wdata,
   output logic                   exc_valid,
   output logic [AW-1:0]          exc_addr,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] mem_addr [DEPTH];
   logic [3:0]    mem_be   [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic [PW-1:0] head, tail, head_nxt;
   logic [CW-1:0] count_nxt, remain;
   logic          legal, push, reject, pop, bypass;
   logic [3:0]    pk_be;
   logic [31:0]   pk_data;
   logic [AW-1:0] pk_addr;

   always_comb begin
      legal   = 1'b0;
      pk_be   = 4'b0000;
      pk_data = in_wdata;
      pk_addr = {in_addr[AW-1:2], 2'b00};
      case (in_type)
         2'b00: begin
            legal = (in_addr[1:0] == 2'b00);
            pk_be = 4'b1111;
         end
         2'b01: begin
            legal   = !in_addr[0];
            pk_be   = 4'b0011 << in_addr[1:0];
            pk_data = {2{in_wdata[15:0]}};
         end
         2'b10: begin
            legal   = 1'b1;
            pk_be   = 4'b0001 << in_addr[1:0];
            pk_data = {4{in_wdata[7:0]}};
         end
         default: legal = 1'b0;
      endcase
   end

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && legal;
   assign reject    = in_valid && in_ready && !legal;
   assign pop       = out_valid && out_ready;

   assign head_nxt  = pop ? head + 1'b1 : head;
   assign remain    = count - CW'(pop);
   assign count_nxt = remain + CW'(push);
   // Entry being written lands directly at the head when nothing else remains queued.
   assign bypass    = push && (remain == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[tail] <= pk_addr;
         mem_be[tail]   <= pk_be;
         mem_data[tail] <= pk_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         out_addr   <= '0;
         out_byteen <= '0;
         out_wdata  <= '0;
         exc_valid  <= 1'b0;
         exc_addr   <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         head      <= head_nxt;
         count     <= count_nxt;
         exc_valid <= reject;
         if (reject)
            exc_addr <= in_addr;
         // Output registers preload the next head so out_* never depend on inputs combinationally.
         if (count_nxt != '0) begin
            if (bypass) begin
               out_addr   <= pk_addr;
               out_byteen <= pk_be;
               out_wdata  <= pk_data;
            end else begin
               out_addr   <= mem_addr[head_nxt];
               out_byteen <= mem_be[head_nxt];
               out_wdata  <= mem_data[head_nxt];
            end
         end
      end
   end
endmodule

// File: tb/tb_store_pack_buffer.sv
// Bench for store_pack_buffer: packing vector table, hand-written flow-control/reset sequences,
// and random traffic checked against a queue-based reference model.
module tb_store_pack_buffer;
   localparam int DEPTH = 2;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_addr = '0;
   logic [31:0]   in_wdata = '0;
   logic [1:0]    in_type = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_addr;
   logic [3:0]    out_byteen;
   logic [31:0]   out_wdata;
   logic          exc_valid;
   logic [31:0]   exc_addr;
   logic [1:0]    count;

   int errors = 0;
   int checks = 0;

   store_pack_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_type(in_type),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_byteen(out_byteen), .out_wdata(out_wdata),
      .exc_valid(exc_valid), .exc_addr(exc_addr), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   ent_t        m_last;
   logic        m_exc;
   logic [31:0] m_exc_addr;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic void ref_pack(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                    output bit ok, output logic [3:0] be, output logic [31:0] w);
      int o;
      o = int'(a % 4);
      ok = 0; be = 4'd0; w = d;
      case (t)
         2'd0: begin ok = (o == 0);     be = 4'd15;       w = d; end
         2'd1: begin ok = (o % 2 == 0); be = 4'(3 << o);  w = (d & 32'hFFFF) * 32'h0001_0001; end
         2'd2: begin ok = 1;            be = 4'(1 << o);  w = (d & 32'hFF) * 32'h0101_0101; end
         default: ok = 0;
      endcase
   endfunction

   function automatic void model_reset();
      q.delete();
      m_last = '{addr: 32'd0, be: 4'd0, data: 32'd0};
      m_exc = 1'b0;
      m_exc_addr = 32'd0;
   endfunction

   // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
   task automatic step(input bit v, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input bit ordy);
      bit ok, acc, pp;
      logic [3:0] be;
      logic [31:0] w;
      in_valid = v; in_type = t; in_addr = a; in_wdata = d; out_ready = ordy;
      ref_pack(t, a, d, ok, be, w);
      acc = v && (q.size() < DEPTH);
      pp  = (q.size() > 0) && ordy;
      if (pp) void'(q.pop_front());
      if (acc && ok) q.push_back('{addr: a & 32'hFFFF_FFFC, be: be, data: w});
      m_exc = acc && !ok;
      if (m_exc) m_exc_addr = a;
      if (q.size() > 0) m_last = q[0];
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".count"},     32'(count),     32'(q.size()));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({tag, ".out_addr"},  out_addr,       m_last.addr);
      chk({tag, ".byteen"},    32'(out_byteen), 32'(m_last.be));
      chk({tag, ".wdata"},     out_wdata,      m_last.data);
      chk({tag, ".exc_valid"}, 32'(exc_valid), 32'(m_exc));
      chk({tag, ".exc_addr"},  exc_addr,       m_exc_addr);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".count"},     32'(count),     32'd0);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
      chk({tag, ".exc_valid"}, 32'(exc_valid), 32'd0);
      chk({tag, ".exc_addr"},  exc_addr,       32'd0);
      chk({tag, ".out_addr"},  out_addr,       32'd0);
   endtask

   typedef struct {
      logic [1:0]  t;
      logic [31:0] a;
      logic [31:0] d;
      bit          exc;
      logic [31:0] oaddr;
      logic [3:0]  be;
      logic [31:0] w;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{2'd0, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF};
      vt[1] = '{2'd2, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5};
      vt[2] = '{2'd1, 32'h0000_3002, 32'h0000_1234, 0, 32'h0000_3000, 4'b1100, 32'h1234_1234};
      vt[3] = '{2'd1, 32'h0000_3000, 32'hFFFF_ABCD, 0, 32'h0000_3000, 4'b0011, 32'hABCD_ABCD};
      vt[4] = '{2'd2, 32'h0000_4001, 32'h1234_5677, 0, 32'h0000_4000, 4'b0010, 32'h7777_7777};
      vt[5] = '{2'd2, 32'h0000_4002, 32'h0000_0C3C, 0, 32'h0000_4000, 4'b0100, 32'h3C3C_3C3C};
      vt[6] = '{2'd0, 32'h0000_0006, 32'h1111_1111, 1, 32'h0, 4'b0, 32'h0};
      vt[7] = '{2'd3, 32'h0000_5000, 32'h2222_2222, 1, 32'h0, 4'b0, 32'h0};
      vt[8] = '{2'd1, 32'h0000_6001, 32'h3333_3333, 1, 32'h0, 4'b0, 32'h0};
      vt[9] = '{2'd0, 32'h0000_7002, 32'h4444_4444, 1, 32'h0, 4'b0, 32'h0};

      model_reset();
      #3;
      check_reset_state("reset");
      #9 reset = 1'b0;
      @(posedge clk); #1;

      // Packing table: each store issued into an empty buffer, then drained.
      for (int i = 0; i < 10; i++) begin
         step(1, vt[i].t, vt[i].a, vt[i].d, 1);
         check_model($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.exc", i), 32'(exc_valid), 32'(vt[i].exc));
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(!vt[i].exc));
         if (vt[i].exc) begin
            chk($sformatf("vec%0d.exc_addr", i), exc_addr, vt[i].a);
         end else begin
            chk($sformatf("vec%0d.addr", i), out_addr, vt[i].oaddr);
            chk($sformatf("vec%0d.be", i), 32'(out_byteen), 32'(vt[i].be));
            chk($sformatf("vec%0d.wdata", i), out_wdata, vt[i].w);
         end
         step(0, 2'd0, 32'h0, 32'h0, 1);
         check_model($sformatf("vec%0d.drain", i));
         chk($sformatf("vec%0d.exc_pulse", i), 32'(exc_valid), 32'd0);
      end

      // Fill to full with the sink stalled; the third store must wait.
      step(1, 2'd0, 32'h100, 32'hA, 0); check_model("full.a");
      step(1, 2'd0, 32'h104, 32'hB, 0); check_model("full.b");
      step(1, 2'd0, 32'h108, 32'hC, 0); check_model("full.c");
      chk("full.count", 32'(count), 32'd2);
      chk("full.in_ready", 32'(in_ready), 32'd0);
      chk("full.stable", out_wdata, 32'hA);
      step(1, 2'd0, 32'h108, 32'hC, 1); check_model("full.pop1");
      chk("full.order1", out_wdata, 32'hB);
      step(1, 2'd0, 32'h108, 32'hC, 1); check_model("full.pop2");
      chk("full.order2", out_wdata, 32'hC);
      step(0, 2'd0, 32'h0, 32'h0, 1); check_model("full.pop3");

      // Steady push+pop at count==1 walks the pointers around several times.
      step(1, 2'd0, 32'h200, 32'h50, 0); check_model("pp.seed");
      for (int i = 0; i < 8; i++) begin
         step(1, 2'd0, 32'h204 + 32'(4 * i), 32'h51 + 32'(i), 1);
         check_model($sformatf("pp%0d", i));
         chk($sformatf("pp%0d.count", i), 32'(count), 32'd1);
         chk($sformatf("pp%0d.data", i), out_wdata, 32'h51 + 32'(i));
      end
      step(0, 2'd0, 32'h0, 32'h0, 1); check_model("pp.drain");

      // Asynchronous reset with a full buffer.
      step(1, 2'd0, 32'h300, 32'h1, 0);
      step(1, 2'd0, 32'h304, 32'h2, 0);
      check_model("rst1.pre");
      in_valid = 1'b0;
      reset = 1'b1; #2;
      model_reset();
      check_reset_state("rst1");
      reset = 1'b0; #1;

      // Asynchronous reset with a pending exception pulse.
      step(1, 2'd0, 32'h400, 32'h7, 0);
      step(1, 2'd3, 32'h404, 32'h8, 0);
      check_model("rst2.pre");
      chk("rst2.pre_exc", 32'(exc_valid), 32'd1);
      in_valid = 1'b0;
      reset = 1'b1; #2;
      model_reset();
      check_reset_state("rst2");
      reset = 1'b0; #1;

      // Random traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, d;
         a = {20'h0, 10'($urandom), 2'($urandom)};
         d = $urandom;
         step(($urandom_range(0, 3) != 0), 2'($urandom), a, d, ($urandom_range(0, 2) != 0));
         check_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
